// File: rtl/svi_lane_collector_if.sv
// Three-wire SVI lane: x is an event strobe level, y/z are payload bits.
// Modport C is the consumer view used by svi_lane_collector.
interface I;
  logic x;
  logic y;
  logic z;

  modport C (
    input x,
    input y,
    input z
  );
endinterface

// File: rtl/svi_lane_collector.sv
// Collects rising edges of x on every SVI lane, queues one pending event per lane,
// and serialises them round-robin onto a single valid/ready output stream.
module svi_lane_collector #(
  parameter  int SIZE   = 8,
  localparam int LANE_W = $clog2(SIZE)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  I.C                       p [SIZE-1:0],
  input  logic              i_ready,
  input  logic              i_ovf_clr,
  output logic              o_valid,
  output logic [LANE_W-1:0] o_lane,
  output logic              o_y,
  output logic              o_z,
  output logic [SIZE-1:0]   o_ovf
);

  logic [SIZE-1:0]   x_in_s;
  logic [SIZE-1:0]   y_in_s;
  logic [SIZE-1:0]   z_in_s;
  logic [SIZE-1:0]   x_q_r;
  logic [SIZE-1:0]   y_q_r;
  logic [SIZE-1:0]   z_q_r;
  logic [SIZE-1:0]   x_qq_r;
  logic [SIZE-1:0]   rise_s;
  logic [SIZE-1:0]   pend_r;
  logic [SIZE-1:0]   pay_y_r;
  logic [SIZE-1:0]   pay_z_r;
  logic [SIZE-1:0]   pend_nx_s;
  logic [SIZE-1:0]   pay_y_nx_s;
  logic [SIZE-1:0]   pay_z_nx_s;
  logic [SIZE-1:0]   ovf_set_s;
  logic [LANE_W-1:0] ptr_r;
  logic [LANE_W:0]   idx_s;
  logic [LANE_W-1:0] grant_s;
  logic              grant_vld_s;
  logic              gnt_now_s;
  logic              gnt_lane_s;
  logic              free_s;

  // Lane index successor, wrapping at SIZE (SIZE need not be a power of two).
  function automatic logic [LANE_W-1:0] next_lane(input logic [LANE_W-1:0] lane);
    return (lane == LANE_W'(SIZE - 1)) ? {LANE_W{1'b0}} : lane + LANE_W'(1);
  endfunction

  for (genvar g = 0; g < SIZE; g++) begin : g_lane
    assign x_in_s[g] = p[g].x;
    assign y_in_s[g] = p[g].y;
    assign z_in_s[g] = p[g].z;
  end

  assign rise_s    = x_q_r & ~x_qq_r;
  assign free_s    = ~o_valid | i_ready;
  assign gnt_now_s = free_s & grant_vld_s;

  // Input sampling and edge-detect history; x_qq starts low so a level high at reset release is a rise.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      x_q_r  <= {SIZE{1'b0}};
      y_q_r  <= {SIZE{1'b0}};
      z_q_r  <= {SIZE{1'b0}};
      x_qq_r <= {SIZE{1'b0}};
    end else begin
      x_q_r  <= x_in_s;
      y_q_r  <= y_in_s;
      z_q_r  <= z_in_s;
      x_qq_r <= x_q_r;
    end
  end

  // Round-robin search from ptr; scanning backwards lets the nearest pending lane win last.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_s     = {LANE_W{1'b0}};
    idx_s       = {(LANE_W+1){1'b0}};
    for (int k = SIZE - 1; k >= 0; k--) begin
      idx_s       = {1'b0, ptr_r} + (LANE_W+1)'(k);
      idx_s       = (idx_s >= (LANE_W+1)'(SIZE)) ? idx_s - (LANE_W+1)'(SIZE) : idx_s;
      grant_s     = pend_r[idx_s[LANE_W-1:0]] ? idx_s[LANE_W-1:0] : grant_s;
      grant_vld_s = grant_vld_s | pend_r[idx_s[LANE_W-1:0]];
    end
  end

  // Per-lane pending update: a rise on the lane being granted refills it; otherwise a busy lane overflows.
  always_comb begin
    pend_nx_s  = pend_r;
    pay_y_nx_s = pay_y_r;
    pay_z_nx_s = pay_z_r;
    ovf_set_s  = {SIZE{1'b0}};
    gnt_lane_s = 1'b0;
    for (int i = 0; i < SIZE; i++) begin
      gnt_lane_s = gnt_now_s & (grant_s == LANE_W'(i));
      if (rise_s[i] && (gnt_lane_s || !pend_r[i])) begin
        pend_nx_s[i]  = 1'b1;
        pay_y_nx_s[i] = y_q_r[i];
        pay_z_nx_s[i] = z_q_r[i];
      end else if (gnt_lane_s) begin
        pend_nx_s[i] = 1'b0;
      end else if (rise_s[i]) begin
        ovf_set_s[i] = 1'b1;
      end else begin
        pend_nx_s[i] = pend_r[i];
      end
    end
  end

  // Pending flags, payloads and sticky overflow (a new overflow beats a same-cycle clear).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pend_r  <= {SIZE{1'b0}};
      pay_y_r <= {SIZE{1'b0}};
      pay_z_r <= {SIZE{1'b0}};
      o_ovf   <= {SIZE{1'b0}};
    end else begin
      pend_r  <= pend_nx_s;
      pay_y_r <= pay_y_nx_s;
      pay_z_r <= pay_z_nx_s;
      o_ovf   <= (i_ovf_clr ? {SIZE{1'b0}} : o_ovf) | ovf_set_s;
    end
  end

  // Output slot and RR pointer; everything holds while a presented event is stalled.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid <= 1'b0;
      o_lane  <= {LANE_W{1'b0}};
      o_y     <= 1'b0;
      o_z     <= 1'b0;
      ptr_r   <= {LANE_W{1'b0}};
    end else if (free_s) begin
      if (grant_vld_s) begin
        o_valid <= 1'b1;
        o_lane  <= grant_s;
        o_y     <= pay_y_r[grant_s];
        o_z     <= pay_z_r[grant_s];
        ptr_r   <= next_lane(grant_s);
      end else begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_svi_lane_collector.sv
// Self-checking bench for svi_lane_collector: directed scenarios plus random traffic,
// all compared each cycle against an event-level reference model.
module tb_svi_lane_collector;
  localparam int SIZE   = 8;
  localparam int LANE_W = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ready;
  logic              ovf_clr;
  logic [SIZE-1:0]   tx, ty, tz;
  logic              o_valid;
  logic [LANE_W-1:0] o_lane;
  logic              o_y, o_z;
  logic [SIZE-1:0]   o_ovf;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [SIZE-1:0] m_xq, m_xqq, m_yq, m_zq, m_pend, m_py, m_pz, m_ovf;
  logic            m_valid, m_y, m_z;
  int              m_lane, m_ptr;

  I lanes [SIZE-1:0] ();
  for (genvar g = 0; g < SIZE; g++) begin : g_drv
    assign lanes[g].x = tx[g];
    assign lanes[g].y = ty[g];
    assign lanes[g].z = tz[g];
  end

  svi_lane_collector #(.SIZE(SIZE)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .p         (lanes),
    .i_ready   (ready),
    .i_ovf_clr (ovf_clr),
    .o_valid   (o_valid),
    .o_lane    (o_lane),
    .o_y       (o_y),
    .o_z       (o_z),
    .o_ovf     (o_ovf)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_xq = '0; m_xqq = '0; m_yq = '0; m_zq = '0;
    m_pend = '0; m_py = '0; m_pz = '0; m_ovf = '0;
    m_valid = 1'b0; m_y = 1'b0; m_z = 1'b0; m_lane = 0; m_ptr = 0;
  endtask

  // One clock edge of the event-level rules, using the inputs the DUT is about to sample.
  task automatic model_edge();
    logic [SIZE-1:0] rise, npend, ny, nz, oset;
    int grant;
    bit free;
    rise  = m_xq & ~m_xqq;
    free  = !m_valid || ready;
    grant = -1;
    if (free) begin
      for (int k = 0; k < SIZE; k++) begin
        if (grant < 0 && m_pend[(m_ptr + k) % SIZE]) grant = (m_ptr + k) % SIZE;
      end
    end
    npend = m_pend; ny = m_py; nz = m_pz; oset = '0;
    for (int i = 0; i < SIZE; i++) begin
      if (i == grant) begin
        npend[i] = rise[i];
        if (rise[i]) begin ny[i] = m_yq[i]; nz[i] = m_zq[i]; end
      end else if (rise[i]) begin
        if (!m_pend[i]) begin npend[i] = 1'b1; ny[i] = m_yq[i]; nz[i] = m_zq[i]; end
        else oset[i] = 1'b1;
      end
    end
    if (free) begin
      if (grant >= 0) begin
        m_valid = 1'b1; m_lane = grant; m_y = m_py[grant]; m_z = m_pz[grant];
        m_ptr = (grant + 1) % SIZE;
      end else begin
        m_valid = 1'b0;
      end
    end
    m_ovf  = (ovf_clr ? '0 : m_ovf) | oset;
    m_pend = npend; m_py = ny; m_pz = nz;
    m_xqq  = m_xq; m_xq = tx; m_yq = ty; m_zq = tz;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check("m_valid", o_valid, m_valid);
    check("m_lane", o_lane, m_lane);
    check("m_y", o_y, m_y);
    check("m_z", o_z, m_z);
    check("m_ovf", o_ovf, m_ovf);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; tx = '0; ty = '0; tz = '0; ready = 1'b0; ovf_clr = 1'b0;
    #1;
    model_reset();
    check("rst_valid", o_valid, 32'd0);
    check("rst_lane", o_lane, 32'd0);
    check("rst_yz", {o_y, o_z}, 32'd0);
    check("rst_ovf", o_ovf, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [SIZE-1:0] sy, sz;
    int cnt;
    int seen[$];

    // 1: single event, then a held level gives nothing more
    do_reset();
    ready = 1'b1; tx[3] = 1'b1; ty[3] = 1'b1; tz[3] = 1'b0;
    step(); step();
    check("t1_early", o_valid, 32'd0);
    step();
    check("t1_valid", o_valid, 32'd1);
    check("t1_lane", o_lane, 32'd3);
    check("t1_yz", {o_y, o_z}, 32'b10);
    step();
    check("t1_single", o_valid, 32'd0);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin step(); cnt += int'(o_valid); end
    check("t1_held", cnt, 32'd0);

    // 2: all lanes together drain in index order, pointer wraps back to 0
    do_reset();
    ready = 1'b1; sy = 8'($urandom); sz = 8'($urandom);
    ty = sy; tz = sz; tx = 8'hFF;
    step(); step();
    for (int k = 0; k < SIZE; k++) begin
      step();
      check("t2_valid", o_valid, 32'd1);
      check("t2_lane", o_lane, k);
      check("t2_yz", {o_y, o_z}, {sy[k], sz[k]});
    end
    tx = '0;
    step();
    check("t2_done", o_valid, 32'd0);
    step(); step();
    tx = 8'h81;
    step(); step(); step();
    check("t2_ptr0", o_lane, 32'd0);
    step();
    check("t2_ptr7", o_lane, 32'd7);

    // 3: backpressure holds the presented event
    do_reset();
    tx = 8'h44;
    step(); step(); step();
    check("t3_valid", o_valid, 32'd1);
    check("t3_lane", o_lane, 32'd2);
    for (int i = 0; i < 5; i++) begin
      step();
      check("t3_hold_v", o_valid, 32'd1);
      check("t3_hold_l", o_lane, 32'd2);
    end
    ready = 1'b1;
    step();
    check("t3_next", o_lane, 32'd6);
    check("t3_next_v", o_valid, 32'd1);
    step();
    check("t3_empty", o_valid, 32'd0);

    // 4: overflow on lane 5 while pending, first pending payload kept
    do_reset();
    tx[5] = 1'b1; ty[5] = 1'b1; tz[5] = 1'b1;
    step(); step(); step();
    check("t4_first", {o_valid, o_y, o_z}, 32'b111);
    tx[5] = 1'b0; step();
    tx[5] = 1'b1; ty[5] = 1'b0; tz[5] = 1'b1; step(); step();
    tx[5] = 1'b0; step();
    tx[5] = 1'b1; ty[5] = 1'b1; tz[5] = 1'b0; step(); step();
    check("t4_ovf", o_ovf, 32'h20);
    ready = 1'b1;
    step();
    check("t4_kept_l", o_lane, 32'd5);
    check("t4_kept_yz", {o_valid, o_y, o_z}, 32'b101);
    step();
    check("t4_drained", o_valid, 32'd0);
    check("t4_sticky", o_ovf, 32'h20);
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
    check("t4_clr", o_ovf, 32'd0);

    // 5: rise coinciding with the grant of the same lane re-arms it
    do_reset();
    tx = 8'h03; ty[1] = 1'b1; tz[1] = 1'b0;
    step(); step(); step();
    check("t5_lane0", o_lane, 32'd0);
    tx[1] = 1'b0; step();
    tx[1] = 1'b1; ty[1] = 1'b0; tz[1] = 1'b1; step();
    ready = 1'b1;
    step();
    check("t5_a", {o_valid, 29'd0, o_lane, o_y, o_z}, {1'b1, 29'd0, 3'd1, 2'b10});
    step();
    check("t5_b", {o_valid, 29'd0, o_lane, o_y, o_z}, {1'b1, 29'd0, 3'd1, 2'b01});
    step();
    check("t5_end", o_valid, 32'd0);
    check("t5_noovf", o_ovf, 32'd0);

    // 6: asynchronous reset in the middle of a burst
    do_reset();
    tx = 8'h5A;
    step(); step(); step();
    check("t6_busy", o_valid, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_v", o_valid, 32'd0);
    check("t6_rst_l", o_lane, 32'd0);
    check("t6_rst_yz", {o_y, o_z}, 32'd0);
    check("t6_rst_ovf", o_ovf, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1; ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (o_valid) seen.push_back(int'(o_lane));
    end
    check("t6_count", seen.size(), 32'd4);
    if (seen.size() == 4) begin
      check("t6_e0", seen[0], 32'd1);
      check("t6_e1", seen[1], 32'd3);
      check("t6_e2", seen[2], 32'd4);
      check("t6_e3", seen[3], 32'd6);
    end

    // random traffic against the model
    do_reset();
    for (int i = 0; i < 600; i++) begin
      tx      = tx ^ 8'($urandom & $urandom);
      ty      = 8'($urandom);
      tz      = 8'($urandom);
      ready   = ($urandom_range(0, 3) != 0);
      ovf_clr = ($urandom_range(0, 15) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
